// File: rtl/dram_pkg.sv
// Shared types and PC_data encodings for the 16-chip DRAM readout receiver.
package dram_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    LOW  = 3'd2,
    HIGH = 3'd3,
    DONE = 3'd4
  } state_t;

  // Bit positions inside PC_data
  localparam int PC_SCLK = 0;
  localparam int PC_LDN  = 1;
  localparam int PC_INH  = 2;

  // PC_data patterns per phase: {CLK_INV, SR/LD#, sclk}
  localparam logic [2:0] PC_IDLE = 3'b110;
  localparam logic [2:0] PC_LOAD = 3'b100;
  localparam logic [2:0] PC_LOW  = 3'b010;
  localparam logic [2:0] PC_HIGH = 3'b011;

endpackage

// File: rtl/dram_deser_lane.sv
// One chip lane: NBITS shift register, MSB-first serial capture.
module dram_deser_lane #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [NBITS-1:0] word
);

  // Shift left and take the serial bit into the LSB; first bit ends up as MSB
  always_ff @(posedge clk) begin
    if (shift_en) begin
      word <= {word[NBITS-2:0], serial_in};
    end
  end

endmodule

// File: rtl/dram16_rd_deser.sv
// Drives the external PISO chain and deserialises 16 serial chip lines into words.
module dram16_rd_deser
  import dram_pkg::*;
#(
  parameter int NBITS    = 8,
  parameter int DIV      = 2,
  parameter int LOAD_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [16:1]           DRAM16_data,
  output logic [2:0]            PC_data,
  output logic [16*NBITS-1:0]   data_out,
  output logic                  rd_done,
  output logic                  busy
);

  localparam int CNT_MAX = (DIV > LOAD_CYC) ? DIV : LOAD_CYC;
  localparam int DW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BW      = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] LOAD_LAST = DW'(LOAD_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);

  state_t          state, state_nxt;
  logic [DW-1:0]   div_cnt, div_nxt;
  logic [BW-1:0]   bit_cnt, bit_nxt;
  logic            shift_en;
  logic            capture;
  logic [16*NBITS-1:0] lane_words;

  // State and phase counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
    end
  end

  // Next-state logic; counters clear only when a phase ends
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    shift_en  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          div_nxt   = '0;
        end
      end
      LOAD: begin
        if (div_cnt == LOAD_LAST) begin
          state_nxt = LOW;
          div_nxt   = '0;
          bit_nxt   = '0;
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      LOW: begin
        if (div_cnt == DIV_LAST) begin
          shift_en  = 1'b1;
          state_nxt = HIGH;
          div_nxt   = '0;
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      HIGH: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = DONE;
            capture   = 1'b1;
          end else begin
            bit_nxt   = bit_cnt + BW'(1);
            state_nxt = LOW;
          end
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded purely from the state register
  always_comb begin
    PC_data = PC_IDLE;
    case (state)
      LOAD:    PC_data = PC_LOAD;
      LOW:     PC_data = PC_LOW;
      HIGH:    PC_data = PC_HIGH;
      default: PC_data = PC_IDLE;
    endcase
  end

  assign rd_done = (state == DONE);
  assign busy    = (state != IDLE);

  // Chip k lane feeds slice [k*NBITS-1 -: NBITS]
  for (genvar k = 1; k <= 16; k++) begin : g_lane
    dram_deser_lane #(.NBITS(NBITS)) u_lane (
      .clk       (clk),
      .shift_en  (shift_en),
      .serial_in (DRAM16_data[k]),
      .word      (lane_words[k*NBITS-1 -: NBITS])
    );
  end

  // Result register: updated only on the edge entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (capture) begin
      data_out <= lane_words;
    end
  end

endmodule

// File: tb/tb_dram16_rd_deser.sv
// Bench for dram16_rd_deser: default build plus NBITS=4/DIV=1/LOAD_CYC=1 build.
module tb_dram16_rd_deser;

  localparam int LAT8 = 2 + 2*2*8 + 1;   // LOAD_CYC + 2*DIV*NBITS + 1
  localparam int LAT4 = 1 + 2*1*4 + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0, start4 = 1'b0;
  logic [16:1] din8 = '0, din4 = '0;
  logic [2:0]  pc8, pc4;
  logic [127:0] data8;
  logic [63:0]  data4;
  logic        done8, done4, busy8, busy4;

  always #5 clk = ~clk;

  dram16_rd_deser dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .DRAM16_data(din8),
    .PC_data(pc8), .data_out(data8), .rd_done(done8), .busy(busy8)
  );

  dram16_rd_deser #(.NBITS(4), .DIV(1), .LOAD_CYC(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .DRAM16_data(din4),
    .PC_data(pc4), .data_out(data4), .rd_done(done4), .busy(busy4)
  );

  // selected-DUT views
  bit          sel = 1'b0;
  logic [2:0]  pc_s;
  logic [127:0] data_s;
  logic        done_s, busy_s;
  assign pc_s   = sel ? pc4 : pc8;
  assign data_s = sel ? {64'b0, data4} : data8;
  assign done_s = sel ? done4 : done8;
  assign busy_s = sel ? busy4 : busy8;

  int n_checks = 0;
  int n_pass   = 0;

  // chip words presented by the external chain model
  logic [7:0] word8 [1:16];
  logic [3:0] word4 [1:16];
  logic [127:0] exp8_q[$];
  logic [127:0] exp4_q[$];

  // observation results
  int done_q[$];
  logic [127:0] got_q[$];
  int rises, ldn_cnt, ldn_first, ldn_last, busy_cnt, busy_first, busy_last, bad_change;

  // External PISO chain model: parallel load while SR/LD# low, shift on rising sclk
  initial begin
    logic [7:0] sr8 [1:16];
    logic [3:0] sr4 [1:16];
    logic p8, p4, l8, l4;
    logic [127:0] e8;
    logic [127:0] e4;
    for (int k = 1; k <= 16; k++) begin sr8[k] = '0; sr4[k] = '0; end
    p8 = 0; p4 = 0; l8 = 1; l4 = 1;
    forever begin
      @(negedge clk);
      if (!pc8[1] && l8) begin
        e8 = '0;
        for (int k = 1; k <= 16; k++) e8[k*8-1 -: 8] = word8[k];
        exp8_q.push_back(e8);
      end
      if (!pc4[1] && l4) begin
        e4 = '0;
        for (int k = 1; k <= 16; k++) e4[k*4-1 -: 4] = word4[k];
        exp4_q.push_back(e4);
      end
      for (int k = 1; k <= 16; k++) begin
        if (!pc8[1]) sr8[k] = word8[k];
        else if (pc8[0] && !p8) sr8[k] = {sr8[k][6:0], 1'b0};
        din8[k] = sr8[k][7];
        if (!pc4[1]) sr4[k] = word4[k];
        else if (pc4[0] && !p4) sr4[k] = {sr4[k][2:0], 1'b0};
        din4[k] = sr4[k][3];
      end
      p8 = pc8[0]; l8 = pc8[1];
      p4 = pc4[0]; l4 = pc4[1];
    end
  end

  task automatic drive_start(input logic v);
    if (sel) start4 = v; else start8 = v;
  endtask

  task automatic scramble_words();
    for (int k = 1; k <= 16; k++) begin
      word8[k] = 8'($urandom_range(0, 255));
      word4[k] = 4'($urandom_range(0, 15));
    end
  endtask

  function automatic logic [127:0] expect8();
    logic [127:0] e = '0;
    for (int k = 1; k <= 16; k++) e[k*8-1 -: 8] = word8[k];
    return e;
  endfunction

  function automatic logic [127:0] expect4();
    logic [127:0] e = '0;
    for (int k = 1; k <= 16; k++) e[k*4-1 -: 4] = word4[k];
    return e;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy_s; i++) begin @(posedge clk); #1; end
    if (busy_s) begin
      n_checks++;
      $display("FAIL wait_idle: busy still %0b after 200 cycles, required 0", busy_s);
    end
  endtask

  // Issue start in cycle T and record what happens over cycles T+1..T+ncyc
  task automatic observe(input int ncyc, input bit hold, input int inj_a, input int inj_b,
                         input bit scramble);
    logic prev_sclk;
    logic [127:0] prev_data;
    wait_idle();
    done_q.delete(); got_q.delete(); exp8_q.delete(); exp4_q.delete();
    rises = 0; ldn_cnt = 0; ldn_first = -1; ldn_last = -1;
    busy_cnt = 0; busy_first = -1; busy_last = -1; bad_change = 0;
    @(posedge clk); #1;
    drive_start(1'b1);
    prev_sclk = pc_s[0];
    prev_data = data_s;
    @(posedge clk); #1;
    for (int n = 1; n <= ncyc; n++) begin
      drive_start(hold || n == inj_a || n == inj_b);
      if (done_s) begin
        done_q.push_back(n);
        got_q.push_back(data_s);
        if (scramble) scramble_words();
      end
      if (busy_s) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = n;
        busy_last = n;
      end
      if (!pc_s[1]) begin
        ldn_cnt++;
        if (ldn_first < 0) ldn_first = n;
        ldn_last = n;
      end
      if (pc_s[0] && !prev_sclk) rises++;
      if (data_s !== prev_data && !done_s) bad_change++;
      prev_sclk = pc_s[0];
      prev_data = data_s;
      @(posedge clk); #1;
    end
    drive_start(1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (pc8 !== 3'b110) $display("FAIL reset_pc: got %b, required 110", pc8); else n_pass++;
    n_checks++;
    if (data8 !== '0 || data4 !== '0) $display("FAIL reset_data: got %h/%h, required 0", data8, data4); else n_pass++;
    n_checks++;
    if ({done8, busy8, done4, busy4} !== 4'b0) $display("FAIL reset_flags: got %b, required 0000", {done8, busy8, done4, busy4}); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (pc4 !== 3'b110 || busy4 !== 1'b0) $display("FAIL idle_after_reset: pc4=%b busy4=%b, required 110/0", pc4, busy4); else n_pass++;
  endtask

  task automatic test_basic();
    sel = 0;
    for (int k = 1; k <= 16; k++) word8[k] = 8'(8'h10 + k);
    observe(45, 0, 0, 0, 0);
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != LAT8) $display("FAIL basic_latency: done count %0d first %0d, required 1 at %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, LAT8); else n_pass++;
    n_checks++;
    if (got_q.size() < 1 || got_q[0][7:0] !== 8'h11 || got_q[0][127:120] !== 8'h20) $display("FAIL basic_chip1_16: got %h, required chip1 11 chip16 20", (got_q.size() > 0) ? got_q[0] : 128'hx); else n_pass++;
    n_checks++;
    if (data8 !== expect8()) $display("FAIL basic_word: got %h, required %h", data8, expect8()); else n_pass++;
    n_checks++;
    if (rises != 8) $display("FAIL basic_sclk_rises: got %0d, required 8", rises); else n_pass++;
    n_checks++;
    if (ldn_cnt != 2 || ldn_first != 1 || ldn_last != 2) $display("FAIL basic_load_window: cnt %0d first %0d last %0d, required 2/1/2", ldn_cnt, ldn_first, ldn_last); else n_pass++;
  endtask

  task automatic test_pattern();
    sel = 0;
    for (int k = 1; k <= 16; k++) word8[k] = (k % 2 == 1) ? 8'hA5 : 8'h5A;
    observe(40, 0, 0, 0, 0);
    n_checks++;
    if (data8 !== {8{16'h5AA5}}) $display("FAIL pattern_word: got %h, required %h", data8, {8{16'h5AA5}}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    sel = 0;
    scramble_words();
    observe(110, 1, 0, 0, 1);
    n_checks++;
    if (done_q.size() != 3 || done_q[0] != LAT8 || done_q[1] != LAT8 + 36 || done_q[2] != LAT8 + 72)
      $display("FAIL b2b_spacing: %0d pulses first %0d, required 3 at %0d/+36/+72", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, LAT8);
    else n_pass++;
    n_checks++;
    if (bad_change != 0) $display("FAIL b2b_data_stable: %0d off-done changes, required 0", bad_change); else n_pass++;
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      n_checks++;
      if (i >= exp8_q.size() || got_q[i] !== exp8_q[i]) $display("FAIL b2b_word%0d: got %h, required %h", i, got_q[i], (i < exp8_q.size()) ? exp8_q[i] : 128'hx); else n_pass++;
    end
  endtask

  task automatic test_ignored_start();
    sel = 0;
    scramble_words();
    observe(45, 0, 5, LAT8, 0);
    n_checks++;
    if (done_q.size() != 1) $display("FAIL ign_done_count: got %0d, required 1", done_q.size()); else n_pass++;
    n_checks++;
    if (busy_first != 1 || busy_last != LAT8 || busy_cnt != LAT8) $display("FAIL ign_busy_window: first %0d last %0d cnt %0d, required 1/%0d/%0d", busy_first, busy_last, busy_cnt, LAT8, LAT8); else n_pass++;
    n_checks++;
    if (data8 !== expect8()) $display("FAIL ign_word: got %h, required %h", data8, expect8()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    sel = 0;
    scramble_words();
    wait_idle();
    @(posedge clk); #1;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pc8 !== 3'b110) $display("FAIL mid_reset_pc: got %b, required 110", pc8); else n_pass++;
    n_checks++;
    if (data8 !== '0) $display("FAIL mid_reset_data: got %h, required 0", data8); else n_pass++;
    n_checks++;
    if (busy8 !== 1'b0) $display("FAIL mid_reset_busy: got %b, required 0", busy8); else n_pass++;
    seen = 0;
    repeat (3) begin @(posedge clk); #1; if (done8) seen++; end
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (done8 || busy8) seen++; end
    n_checks++;
    if (seen != 0) $display("FAIL mid_reset_quiet: %0d done/busy cycles, required 0", seen); else n_pass++;
    scramble_words();
    observe(40, 0, 0, 0, 0);
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != LAT8 || data8 !== expect8()) $display("FAIL mid_reset_reread: done %0d got %h, required %0d %h", (done_q.size() > 0) ? done_q[0] : -1, data8, LAT8, expect8()); else n_pass++;
  endtask

  task automatic test_small_variant();
    sel = 1;
    for (int k = 1; k <= 16; k++) word4[k] = 4'(k);
    observe(15, 0, 0, 0, 0);
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != LAT4) $display("FAIL var_latency: count %0d first %0d, required 1 at %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, LAT4); else n_pass++;
    n_checks++;
    if (data4 !== 64'h0FEDCBA987654321) $display("FAIL var_word: got %h, required 0fedcba987654321", data4); else n_pass++;
    n_checks++;
    if (rises != 4 || ldn_cnt != 1) $display("FAIL var_pc: rises %0d load cycles %0d, required 4/1", rises, ldn_cnt); else n_pass++;
    sel = 0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      scramble_words();
      sel = 0;
      observe(40, 0, 0, 0, 0);
      n_checks++;
      if (done_q.size() != 1 || data8 !== expect8()) $display("FAIL rand8_%0d: got %h, required %h", it, data8, expect8()); else n_pass++;
      sel = 1;
      observe(15, 0, 0, 0, 0);
      n_checks++;
      if (done_q.size() != 1 || {64'b0, data4} !== expect4()) $display("FAIL rand4_%0d: got %h, required %h", it, data4, expect4()[63:0]); else n_pass++;
    end
    sel = 0;
  endtask

  initial begin
    for (int k = 1; k <= 16; k++) begin word8[k] = '0; word4[k] = '0; end
    test_reset();
    test_basic();
    test_pattern();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_small_variant();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dram16_rd_deser.md
Name: dram16_rd_deser

Overview:
- FPGA-side receiver for the 16-chip DRAM readout path.
- Drives the external parallel-in/serial-out shift-register chain through PC_data and deserialises the 16 serial lines on DRAM16_data into one NBITS-wide word per chip.
- Sits between the DRAM read controller, which asserts start after RD_EN/VSAEN sensing completes, and the DRAM_DATA_OUT1..16 registers. It is the reader counterpart of the D_IN/R_AD serialisers.

Parameters:
- NBITS, 8: bits captured per chip per transaction.
- DIV, 2: shift-clock half-period in clk cycles (>=1).
- LOAD_CYC, 2: cycles SR/LD# is held low for the parallel load (>=1).

Ports:
- clk  in  1  system clock (clk_100m domain); one clock only.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request one readout; sampled only in IDLE.
- DRAM16_data  in  16 [16:1]  serial outputs of the chip shift registers; bit k belongs to chip k.
- PC_data  out  3  shift-register control: [0]=shift clock, [1]=SR/LD# (0 = load, 1 = shift), [2]=CLK_INV (clock inhibit, 1 = inhibit).
- data_out  out  16*NBITS  captured words; chip k occupies [k*NBITS-1 -: NBITS], so chip1 is [NBITS-1:0].
- rd_done  out  1  one-cycle pulse; data_out is valid from this cycle onward.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (asynchronous, any state): PC_data=3'b110, data_out=0, rd_done=0, busy=0, FSM in IDLE, counters 0.
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- IDLE: PC_data=3'b110. start=1 moves the FSM to LOAD on the next edge.
- LOAD:
  - PC_data=3'b100 (inhibit high, SR/LD# low, sclk low).
  - Stays LOAD_CYC cycles, then goes to LOW with bit_cnt=0.
- LOW:
  - PC_data=3'b010.
  - Stays DIV cycles.
  - On the last LOW cycle, every lane shifts left and takes the serial bit into its LSB: sh_k <= {sh_k[NBITS-2:0], DRAM16_data[k]}. The first sample is therefore the MSB of the chip word.
  - Then goes to HIGH.
- HIGH:
  - PC_data=3'b011 (rising shift-clock edge at entry).
  - Stays DIV cycles.
  - If bit_cnt==NBITS-1, goes to DONE; otherwise bit_cnt+1 and goes to LOW.
  - Exactly NBITS rising edges are issued per transaction.
- DONE:
  - PC_data=3'b110, rd_done=1, busy=1.
  - data_out is loaded from the shift registers on the edge entering DONE.
  - Goes to IDLE next cycle.
- Latency: start accepted in cycle T gives LOAD at T+1, rd_done at T+LOAD_CYC+2*DIV*NBITS+1. Defaults give T+35.
- data_out holds its value until the next DONE. It never changes mid-transaction.
- start while busy (including the DONE cycle) is ignored. It is not queued. start held high in IDLE starts a new transaction each time IDLE is re-entered, so back-to-back spacing is latency+1 cycles.
- Reset asserted mid-transaction:
  - Immediate abort with reset values, including data_out=0.
  - No rd_done.
  - After release, the FSM waits in IDLE for a fresh start.
- Counters: div_cnt is $clog2(max(DIV,LOAD_CYC)) bits and bit_cnt is $clog2(NBITS) bits. Both wrap to 0 only on phase exit, never by overflow.
- DRAM16_data is treated as synchronous to clk. The external chain is clocked from PC_data, and setup is guaranteed by DIV>=1.

Decomposition:
- Shared package dram_pkg holds:
  - state enum (IDLE, LOAD, LOW, HIGH, DONE);
  - PC_data bit index constants (PC_SCLK=0, PC_LDN=1, PC_INH=2);
  - PC_IDLE/PC_LOAD/PC_LOW/PC_HIGH encodings.
- One sub-module, dram_deser_lane: an NBITS shift register with shift enable and serial input. It is instantiated 16 times via generate. The FSM and counters stay in the top.

Test Plan:
- Chip k presents byte 8'h10+k MSB-first (default params), start pulse at T -> rd_done only at T+35; chip1 word=8'h11, chip16=8'h20; exactly 8 rising PC_data[0] edges; PC_data[1] low only in T+1..T+2.
- All chips 8'hA5 on odd k and 8'h5A on even k -> data_out=128'h5AA5 repeated; checks lane-to-slice mapping and bit order.
- start held high continuously -> rd_done pulses every 36 cycles; data_out updates only on rd_done cycles.
- start pulses at T+5 and at the DONE cycle of a transaction -> both ignored; exactly one rd_done; busy high from T+1 through DONE.
- rst_n low at T+12 mid-shift -> PC_data=3'b110, data_out=0, busy=0 immediately; no rd_done; a later start gives a correct full read.
- DIV=1, LOAD_CYC=1, NBITS=4 variant, chip k nibble = k[3:0] -> rd_done at T+10; words match.
